boid_mem_seq: RTL and testbench

Memory-side sequencer for the boid accelerator datapath. Drives one full frame update: for each focal boid it loads that boid's x/y/vx/vy record, streams every other boid's record through the accelerator, then captures the accelerator's updated record and writes it back. Boid state is double-banked in M10K (read bank / write bank) so that writes never disturb the same frame's neighbour reads. The sequencer sits between the boid M10K banks and the accelerator datapath.

---
 rtl/boid_pkg.sv | 23 ++
 rtl/boid_mem_seq_if.sv | 55 +++++
 rtl/boid_idx_ctr.sv | 26 ++
 rtl/boid_mem_seq.sv | 146 ++++++++++++++
 tb/tb_boid_mem_seq.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boid_pkg.sv
// Shared types and default sizes for the boid memory sequencer.
package boid_pkg;

    localparam int N_BOIDS_DEF = 32;
    localparam int IDX_W_DEF   = 6;

    typedef enum logic [2:0] {
        IDLE,
        FRD,
        FLD,
        ITR,
        WB
    } seq_state_t;

    // fix15 record, one per boid
    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] vx;
        logic signed [31:0] vy;
    } boid_rec_t;

endpackage

// File: rtl/boid_mem_seq_if.sv
// Bundle between the sequencer, the double-banked M10K store and the accelerator.
interface boid_mem_seq_if #(
    parameter int IDX_W = 6
);

    logic             start;
    logic             busy;
    logic             done;
    logic             frame_sel;
    logic [IDX_W-1:0] mem_raddr;
    logic [31:0]      mem_rdata_x;
    logic [31:0]      mem_rdata_y;
    logic [31:0]      mem_rdata_vx;
    logic [31:0]      mem_rdata_vy;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata_x;
    logic [31:0]      mem_wdata_y;
    logic [31:0]      mem_wdata_vx;
    logic [31:0]      mem_wdata_vy;
    logic [31:0]      x_in_xcel;
    logic [31:0]      y_in_xcel;
    logic [31:0]      vx_in_xcel;
    logic [31:0]      vy_in_xcel;
    logic             r_en_tot;
    logic             r_en_itr;
    logic [6:0]       wb_en;
    logic [31:0]      x_out_xcel;
    logic [31:0]      y_out_xcel;
    logic [31:0]      vx_out_xcel;
    logic [31:0]      vy_out_xcel;

    modport master (
        input  start,
        input  mem_rdata_x, mem_rdata_y, mem_rdata_vx, mem_rdata_vy,
        input  x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel,
        output busy, done, frame_sel,
        output mem_raddr, mem_we, mem_waddr,
        output mem_wdata_x, mem_wdata_y, mem_wdata_vx, mem_wdata_vy,
        output x_in_xcel, y_in_xcel, vx_in_xcel, vy_in_xcel,
        output r_en_tot, r_en_itr, wb_en
    );

    modport slave (
        output start,
        output mem_rdata_x, mem_rdata_y, mem_rdata_vx, mem_rdata_vy,
        output x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel,
        input  busy, done, frame_sel,
        input  mem_raddr, mem_we, mem_waddr,
        input  mem_wdata_x, mem_wdata_y, mem_wdata_vx, mem_wdata_vy,
        input  x_in_xcel, y_in_xcel, vx_in_xcel, vy_in_xcel,
        input  r_en_tot, r_en_itr, wb_en
    );

endinterface

// File: rtl/boid_idx_ctr.sv
// Index up-counter cleared to zero on load; saturates at LAST, never wraps.
module boid_idx_ctr #(
    parameter int IDX_W = 6,
    parameter int LAST  = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    output logic [IDX_W-1:0] count,
    output logic             tc
);

    assign tc = (count == IDX_W'(LAST));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + IDX_W'(1);
        end
    end

endmodule

// File: rtl/boid_mem_seq.sv
// Frame sequencer: per focal boid load it, stream all neighbours through
// the accelerator, then write the updated record into the other bank.
module boid_mem_seq
    import boid_pkg::*;
#(
    parameter int N_BOIDS = N_BOIDS_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int WB_LAT  = 1
) (
    input logic           clk,
    input logic           reset,
    boid_mem_seq_if.master bus
);

    localparam int WB_W = (WB_LAT < 2) ? 1 : $clog2(WB_LAT);
    localparam logic [WB_W-1:0] WB_LAST = WB_W'(WB_LAT - 1);
    localparam logic WE_AT_ENTRY = (WB_LAT == 1);

    seq_state_t       state;
    logic [WB_W-1:0]  wb_cnt;
    logic [WB_W-1:0]  wb_nxt;
    logic             wb0;
    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] j_idx;
    logic [IDX_W-1:0] j_nxt;
    logic             i_tc;
    logic             j_tc;
    logic             j_nxt_last;
    logic             wb_last;
    boid_rec_t        out_rec;

    assign wb_nxt     = wb_cnt + WB_W'(1);
    assign wb_last    = (state == WB) && (wb_cnt == WB_LAST);
    assign j_nxt      = j_idx + IDX_W'(1);
    assign j_nxt_last = (j_nxt == IDX_W'(N_BOIDS - 1));

    boid_idx_ctr #(.IDX_W(IDX_W), .LAST(N_BOIDS - 1)) u_i_ctr (
        .clk   (clk),
        .reset (reset),
        .load  ((state == IDLE) && bus.start),
        .inc   (wb_last),
        .count (i_idx),
        .tc    (i_tc)
    );

    boid_idx_ctr #(.IDX_W(IDX_W), .LAST(N_BOIDS - 1)) u_j_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (state == FRD),
        .inc   (state == ITR),
        .count (j_idx),
        .tc    (j_tc)
    );

    // Neighbour records go straight to the accelerator; it samples on its enables.
    assign bus.x_in_xcel  = bus.mem_rdata_x;
    assign bus.y_in_xcel  = bus.mem_rdata_y;
    assign bus.vx_in_xcel = bus.mem_rdata_vx;
    assign bus.vy_in_xcel = bus.mem_rdata_vy;

    assign out_rec = '{
        x:  bus.x_out_xcel,
        y:  bus.y_out_xcel,
        vx: bus.vx_out_xcel,
        vy: bus.vy_out_xcel
    };

    assign bus.mem_wdata_x  = bus.mem_we ? out_rec.x  : '0;
    assign bus.mem_wdata_y  = bus.mem_we ? out_rec.y  : '0;
    assign bus.mem_wdata_vx = bus.mem_we ? out_rec.vx : '0;
    assign bus.mem_wdata_vy = bus.mem_we ? out_rec.vy : '0;
    assign bus.wb_en        = {6'b0, wb0};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            wb_cnt        <= '0;
            wb0           <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.frame_sel <= 1'b0;
            bus.mem_raddr <= '0;
            bus.mem_waddr <= '0;
            bus.mem_we    <= 1'b0;
            bus.r_en_tot  <= 1'b0;
            bus.r_en_itr  <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.r_en_tot <= 1'b0;
            bus.r_en_itr <= 1'b0;
            bus.mem_we   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= FRD;
                        bus.busy      <= 1'b1;
                        bus.mem_raddr <= '0;
                    end
                end
                FRD: begin
                    state         <= FLD;
                    bus.r_en_tot  <= 1'b1;
                    bus.mem_raddr <= '0;
                end
                FLD: begin
                    state         <= ITR;
                    bus.r_en_itr  <= (i_idx != '0);
                    bus.mem_raddr <= IDX_W'(1);
                end
                ITR: begin
                    if (j_tc) begin
                        state         <= WB;
                        wb_cnt        <= '0;
                        wb0           <= 1'b1;
                        bus.mem_waddr <= i_idx;
                        bus.mem_we    <= WE_AT_ENTRY;
                    end else begin
                        bus.r_en_itr <= (j_nxt != i_idx);
                        if (!j_nxt_last) begin
                            bus.mem_raddr <= j_nxt + IDX_W'(1);
                        end
                    end
                end
                WB: begin
                    if (wb_cnt == WB_LAST) begin
                        wb0 <= 1'b0;
                        if (i_tc) begin
                            state         <= IDLE;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.frame_sel <= ~bus.frame_sel;
                        end else begin
                            state         <= FRD;
                            bus.mem_raddr <= i_idx + IDX_W'(1);
                        end
                    end else begin
                        wb_cnt     <= wb_nxt;
                        bus.mem_we <= (wb_nxt == WB_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boid_mem_seq.sv
// Bench for boid_mem_seq: cycle table, write scoreboard with a stub
// accelerator, latency, WB_LAT=3 and mid-frame reset sequences.
module tb_boid_mem_seq;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] vx;
        logic [31:0] vy;
    } rec_t;

    typedef struct {
        int   addr;
        rec_t rec;
    } wr_t;

    typedef struct {
        int   cyc;
        logic busy, tot, itr, wb, we, done, fs;
        int   raddr;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    boid_mem_seq_if #(.IDX_W(2)) a_if ();
    boid_mem_seq_if #(.IDX_W(5)) b_if ();
    boid_mem_seq_if #(.IDX_W(6)) c_if ();

    boid_mem_seq #(.N_BOIDS(4), .IDX_W(2), .WB_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if)
    );
    boid_mem_seq #(.N_BOIDS(32), .IDX_W(5), .WB_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if)
    );
    boid_mem_seq #(.N_BOIDS(32), .IDX_W(6), .WB_LAT(1)) dut_c (
        .clk(clk), .reset(reset), .bus(c_if)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Double-banked memory with 1-cycle read for instance A
    rec_t bank_a [2][4];
    rec_t a_rd;
    always @(posedge clk) begin
        a_rd <= bank_a[a_if.frame_sel][a_if.mem_raddr];
        if (a_if.mem_we)
            bank_a[~a_if.frame_sel][a_if.mem_waddr] <= {a_if.mem_wdata_x,
                a_if.mem_wdata_y, a_if.mem_wdata_vx, a_if.mem_wdata_vy};
    end
    assign a_if.mem_rdata_x  = a_rd.x;
    assign a_if.mem_rdata_y  = a_rd.y;
    assign a_if.mem_rdata_vx = a_rd.vx;
    assign a_if.mem_rdata_vy = a_rd.vy;

    // Stub accelerator: x+1, vx accumulates neighbour x
    rec_t acc_a;
    always @(posedge clk) begin
        if (a_if.r_en_tot)
            acc_a <= {a_if.x_in_xcel, a_if.y_in_xcel,
                      a_if.vx_in_xcel, a_if.vy_in_xcel};
        else if (a_if.r_en_itr)
            acc_a.vx <= acc_a.vx + a_if.x_in_xcel;
    end
    assign a_if.x_out_xcel  = acc_a.x + 32'd1;
    assign a_if.y_out_xcel  = acc_a.y;
    assign a_if.vx_out_xcel = acc_a.vx;
    assign a_if.vy_out_xcel = acc_a.vy;

    assign b_if.mem_rdata_x  = 32'd0;
    assign b_if.mem_rdata_y  = 32'd0;
    assign b_if.mem_rdata_vx = 32'd0;
    assign b_if.mem_rdata_vy = 32'd0;
    assign b_if.x_out_xcel   = 32'h1234_5678;
    assign b_if.y_out_xcel   = 32'd0;
    assign b_if.vx_out_xcel  = 32'd0;
    assign b_if.vy_out_xcel  = 32'd0;
    assign c_if.mem_rdata_x  = 32'd0;
    assign c_if.mem_rdata_y  = 32'd0;
    assign c_if.mem_rdata_vx = 32'd0;
    assign c_if.mem_rdata_vy = 32'd0;
    assign c_if.x_out_xcel   = 32'h0bad_cafe;
    assign c_if.y_out_xcel   = 32'h1;
    assign c_if.vx_out_xcel  = 32'h2;
    assign c_if.vy_out_xcel  = 32'h3;

    rec_t a_model [4];
    rec_t a_next [4];
    wr_t  a_sb [$];
    wr_t  a_e;
    logic a_on = 1'b0;
    logic b_on = 1'b0;
    logic [31:0] a_focal;
    int   a_itr_n = 0;
    int   b_wb_run = 0;
    vec_t vtab [14];

    always @(negedge clk) begin
        if (reset && a_on) begin
            chk("a_tot_itr_excl", a_if.r_en_tot & a_if.r_en_itr, 0);
            chk("a_we_in_wb", a_if.mem_we & ~a_if.wb_en[0], 0);
            if (a_if.r_en_tot) begin
                a_focal = a_if.x_in_xcel;
                a_itr_n = 0;
            end
            if (a_if.r_en_itr) begin
                a_itr_n++;
                chk("a_self_skip", a_if.x_in_xcel != a_focal, 1);
            end
            if (a_if.mem_we) begin
                chk("a_itr_per_boid", a_itr_n, 3);
                chk("a_sb_nonempty", a_sb.size() > 0, 1);
                if (a_sb.size() > 0) begin
                    a_e = a_sb.pop_front();
                    chk("a_waddr", a_if.mem_waddr, a_e.addr);
                    chk("a_wx", a_if.mem_wdata_x, a_e.rec.x);
                    chk("a_wy", a_if.mem_wdata_y, a_e.rec.y);
                    chk("a_wvx", a_if.mem_wdata_vx, a_e.rec.vx);
                    chk("a_wvy", a_if.mem_wdata_vy, a_e.rec.vy);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && b_on) begin
            if (b_if.wb_en[0]) begin
                b_wb_run++;
                chk("b_wb_hi_zero", b_if.wb_en[6:1], 0);
            end
            if (b_if.mem_we) begin
                chk("b_we_on_third_wb", b_wb_run, 3);
                chk("b_wdata_x", b_if.mem_wdata_x, 32'h1234_5678);
            end
            if (!b_if.wb_en[0] && b_wb_run != 0) begin
                chk("b_wb_run_len", b_wb_run, 3);
                b_wb_run = 0;
            end
        end
    end

    task automatic push_frame_a();
        rec_t r;
        for (int i = 0; i < 4; i++) begin
            r = a_model[i];
            r.x = a_model[i].x + 32'd1;
            for (int j = 0; j < 4; j++)
                if (j != i) r.vx = r.vx + a_model[j].x;
            a_next[i] = r;
            a_sb.push_back('{addr: i, rec: r});
        end
    endtask

    function automatic vec_t snap_a(input int k);
        vec_t v;
        v.cyc = k;
        v.busy = a_if.busy;
        v.tot = a_if.r_en_tot;
        v.itr = a_if.r_en_itr;
        v.wb = a_if.wb_en[0];
        v.we = a_if.mem_we;
        v.done = a_if.done;
        v.fs = a_if.frame_sel;
        v.raddr = int'(a_if.mem_raddr);
        return v;
    endfunction

    task automatic run_a(input int f);
        vec_t tr [0:32];
        vec_t e;
        int dn, bz, nt, ni, nw;
        push_frame_a();
        a_on = 1'b1;
        @(negedge clk);
        a_if.start = 1'b1;
        tr[0] = snap_a(0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            a_if.start = (k == 10);
            tr[k] = snap_a(k);
        end
        a_on = 1'b0;
        dn = -1; bz = 0; nt = 0; ni = 0; nw = 0;
        for (int k = 0; k <= 32; k++) begin
            if (tr[k].done && dn < 0) dn = k;
            bz += tr[k].busy ? 1 : 0;
            nt += tr[k].tot ? 1 : 0;
            ni += tr[k].itr ? 1 : 0;
            nw += tr[k].we ? 1 : 0;
        end
        chk("a_done_cycle", dn, 29);
        chk("a_busy_cycles", bz, 28);
        chk("a_tot_count", nt, 4);
        chk("a_itr_count", ni, 12);
        chk("a_we_count", nw, 4);
        chk("a_fs_busy", tr[1].fs, f % 2);
        chk("a_fs_after", tr[30].fs, (f + 1) % 2);
        if (f == 0) begin
            for (int n = 0; n < 14; n++) begin
                e = vtab[n];
                chk($sformatf("a_vec_c%0d_ctl", e.cyc),
                    {tr[e.cyc].busy, tr[e.cyc].tot, tr[e.cyc].itr,
                     tr[e.cyc].wb, tr[e.cyc].we, tr[e.cyc].done,
                     tr[e.cyc].fs},
                    {e.busy, e.tot, e.itr, e.wb, e.we, e.done, e.fs});
                if (e.raddr >= 0)
                    chk($sformatf("a_vec_c%0d_raddr", e.cyc),
                        tr[e.cyc].raddr, e.raddr);
            end
        end
        chk("a_sb_drained", a_sb.size(), 0);
        for (int i = 0; i < 4; i++) begin
            chk("a_rbank_kept", bank_a[f % 2][i] == a_model[i], 1);
            chk("a_wbank_data", bank_a[1 - f % 2][i] == a_next[i], 1);
        end
        a_model = a_next;
    endtask

    task automatic run_bc(input bit c, input int lim, output int dn,
                          output int bz, output int nw);
        dn = -1; bz = 0; nw = 0;
        @(negedge clk);
        if (c) c_if.start = 1'b1;
        else b_if.start = 1'b1;
        for (int k = 1; k <= lim && dn < 0; k++) begin
            @(negedge clk);
            c_if.start = 1'b0;
            b_if.start = 1'b0;
            if (c ? c_if.busy : b_if.busy) bz++;
            if (c ? c_if.mem_we : b_if.mem_we) nw++;
            if (c ? c_if.done : b_if.done) dn = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dn, bz, nw;
        //          cyc bsy tot itr wb we dn fs raddr
        vtab[0]  = '{0,  0, 0, 0, 0, 0, 0, 0, 0};
        vtab[1]  = '{1,  1, 0, 0, 0, 0, 0, 0, 0};
        vtab[2]  = '{2,  1, 1, 0, 0, 0, 0, 0, 0};
        vtab[3]  = '{3,  1, 0, 0, 0, 0, 0, 0, 1};
        vtab[4]  = '{4,  1, 0, 1, 0, 0, 0, 0, 2};
        vtab[5]  = '{6,  1, 0, 1, 0, 0, 0, 0, 3};
        vtab[6]  = '{7,  1, 0, 0, 1, 1, 0, 0, 3};
        vtab[7]  = '{8,  1, 0, 0, 0, 0, 0, 0, 1};
        vtab[8]  = '{9,  1, 1, 0, 0, 0, 0, 0, 0};
        vtab[9]  = '{11, 1, 0, 0, 0, 0, 0, 0, 2};
        vtab[10] = '{12, 1, 0, 1, 0, 0, 0, 0, 3};
        vtab[11] = '{27, 1, 0, 0, 0, 0, 0, 0, 3};
        vtab[12] = '{28, 1, 0, 0, 1, 1, 0, 0, 3};
        vtab[13] = '{29, 0, 0, 0, 0, 0, 1, 1, -1};
        for (int i = 0; i < 4; i++) begin
            bank_a[0][i] = {32'(i) << 16, 32'(i + 100), 32'd0, 32'(i * 3)};
            bank_a[1][i] = '0;
            a_model[i] = bank_a[0][i];
        end
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        c_if.start = 1'b0;

        repeat (3) @(negedge clk);
        chk("a_rst_ctrl", {a_if.busy, a_if.done, a_if.mem_we, a_if.r_en_tot,
                           a_if.r_en_itr, a_if.frame_sel, a_if.wb_en}, 0);
        chk("a_rst_addr", {a_if.mem_raddr, a_if.mem_waddr}, 0);
        chk("a_rst_wdata", a_if.mem_wdata_x | a_if.mem_wdata_y |
                           a_if.mem_wdata_vx | a_if.mem_wdata_vy, 0);
        reset = 1'b1;

        run_a(0);
        run_a(1);

        b_on = 1'b1;
        run_bc(1'b0, 1400, dn, bz, nw);
        b_on = 1'b0;
        chk("b_done_cycle", dn, 1185);
        chk("b_busy_cycles", bz, 1184);
        chk("b_we_count", nw, 32);

        run_bc(1'b1, 1300, dn, bz, nw);
        chk("c_done_cycle", dn, 1121);
        chk("c_busy_cycles", bz, 1120);
        chk("c_we_count", nw, 32);
        chk("c_fs_frame1", c_if.frame_sel, 1);

        @(negedge clk);
        c_if.start = 1'b1;
        @(negedge clk);
        c_if.start = 1'b0;
        chk("c_busy_after_start", c_if.busy, 1);
        repeat (49) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("c_rst_ctrl", {c_if.busy, c_if.done, c_if.mem_we, c_if.r_en_tot,
                           c_if.r_en_itr, c_if.wb_en}, 0);
        chk("c_rst_fs", c_if.frame_sel, 0);
        chk("c_rst_addr", {c_if.mem_raddr, c_if.mem_waddr}, 0);
        chk("c_rst_wdata", c_if.mem_wdata_x | c_if.mem_wdata_y |
                           c_if.mem_wdata_vx | c_if.mem_wdata_vy, 0);
        reset = 1'b1;

        run_bc(1'b1, 1300, dn, bz, nw);
        chk("c_done_after_rst", dn, 1121);
        chk("c_busy_after_rst", bz, 1120);
        chk("c_we_after_rst", nw, 32);
        chk("c_fs_after_rst", c_if.frame_sel, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
